// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared FSM states, default parameters and counter sizing for key_debounce_multi
package key_debounce_pkg;

    localparam int DEF_CH            = 4;
    localparam int DEF_STABLE_CYCLES = 500000;
    localparam int DEF_LONG_CYCLES   = 50000000;

    typedef enum logic [1:0] {
        UP      = 2'd0,
        DN_WAIT = 2'd1,
        DOWN    = 2'd2,
        UP_WAIT = 2'd3
    } key_fsm_t;

    // Wide enough to hold the larger window value itself, so counters saturate instead of wrapping.
    function automatic int cnt_width(input int stable_cycles, input int long_cycles);
        int peak;
        peak = (stable_cycles > long_cycles) ? stable_cycles : long_cycles;
        return $clog2(peak + 1);
    endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// rtl/key_debounce_multi_if.sv - raw key inputs and debounced key outputs (key_long only with KEY_LONG_PRESS_EN)
interface key_debounce_multi_if
    import key_debounce_pkg::*;
#(
    parameter int CH = DEF_CH
);

    logic [CH-1:0] key_n;
    logic [CH-1:0] key_state;
    logic [CH-1:0] key_press;
    logic [CH-1:0] key_release;
    logic [CH-1:0] key_toggle;
`ifdef KEY_LONG_PRESS_EN
    logic [CH-1:0] key_long;
`endif

    modport master (
        output key_n,
        input  key_state,
        input  key_press,
        input  key_release,
`ifdef KEY_LONG_PRESS_EN
        input  key_long,
`endif
        input  key_toggle
    );

    modport slave (
        input  key_n,
        output key_state,
        output key_press,
        output key_release,
`ifdef KEY_LONG_PRESS_EN
        output key_long,
`endif
        output key_toggle
    );

endinterface

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchronizer, debounce FSM, pulses (long press under KEY_LONG_PRESS_EN)
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
`ifdef KEY_LONG_PRESS_EN
    output logic key_long,
`endif
    output logic key_toggle
);

    localparam int              CW          = cnt_width(STABLE_CYCLES, LONG_CYCLES);
    localparam logic [CW-1:0]   STABLE_LAST = CW'(STABLE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          key_s;
    key_fsm_t      state_q;
    key_fsm_t      state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_d;
    logic          release_d;

    assign key_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            UP: begin
                if (!key_s) begin
                    state_d = DN_WAIT;
                    cnt_d   = '0;
                end
            end
            DN_WAIT: begin
                if (key_s) begin
                    state_d = UP;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DOWN: begin
                if (key_s) begin
                    state_d = UP_WAIT;
                    cnt_d   = '0;
                end
            end
            UP_WAIT: begin
                if (!key_s) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d   = UP;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= UP;
            cnt_q       <= '0;
            key_state   <= 1'b1;
            key_toggle  <= 1'b1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_n};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_state   <= (state_d == UP) || (state_d == DN_WAIT);
            key_toggle  <= key_toggle ^ press_d;
            key_press   <= press_d;
            key_release <= release_d;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES);

    logic [CW-1:0] hold_q;
    logic [CW-1:0] hold_d;
    logic          long_d;

    // Hold time accumulates only while settled in DOWN; UP_WAIT bounces pause it without clearing.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if (state_q == DOWN && !key_s) begin
            if (hold_q == LONG_LAST) begin
                long_d = 1'b1;
            end
            if (hold_q != LONG_SAT) begin
                hold_d = hold_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q   <= '0;
            key_long <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            key_long <= long_d;
        end
    end
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - CH independent debounced key channels; KEY_LONG_PRESS_EN adds long-press pulses
module key_debounce_multi
    import key_debounce_pkg::*;
#(
    parameter int CH            = DEF_CH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_debounce_multi_if.slave  kif
);

    logic [CH-1:0] state_v;
    logic [CH-1:0] press_v;
    logic [CH-1:0] release_v;
    logic [CH-1:0] toggle_v;
`ifdef KEY_LONG_PRESS_EN
    logic [CH-1:0] long_v;
`endif

    for (genvar g = 0; g < CH; g++) begin : g_ch
        key_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_n       (kif.key_n[g]),
            .key_state   (state_v[g]),
            .key_press   (press_v[g]),
            .key_release (release_v[g]),
`ifdef KEY_LONG_PRESS_EN
            .key_long    (long_v[g]),
`endif
            .key_toggle  (toggle_v[g])
        );
    end

    assign kif.key_state   = state_v;
    assign kif.key_press   = press_v;
    assign kif.key_release = release_v;
    assign kif.key_toggle  = toggle_v;
`ifdef KEY_LONG_PRESS_EN
    assign kif.key_long    = long_v;
`endif

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - scenario and randomized checks of key_debounce_multi against a run-length model
module tb_key_debounce_multi;

    localparam int CH = 4;
    localparam int S  = 4;
    localparam int L  = 16;
`ifdef KEY_LONG_PRESS_EN
    localparam int VW = 5 * CH;
`else
    localparam int VW = 4 * CH;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    key_debounce_multi_if #(.CH(CH)) kif ();

    key_debounce_multi #(
        .CH            (CH),
        .STABLE_CYCLES (S),
        .LONG_CYCLES   (L)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    // Model: a level change is accepted once the synchronized key has disagreed with the
    // debounced level for S+1 consecutive edges.
    logic          m_s1 [CH];
    logic          m_s2 [CH];
    logic          m_deb[CH];
    logic          m_tog[CH];
    int            m_run[CH];
    logic [CH-1:0] m_press;
    logic [CH-1:0] m_release;
`ifdef KEY_LONG_PRESS_EN
    int            m_held[CH];
    logic [CH-1:0] m_long;
`endif

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            logic ks;
            m_press[c]   = 1'b0;
            m_release[c] = 1'b0;
`ifdef KEY_LONG_PRESS_EN
            m_long[c]    = 1'b0;
`endif
            if (!rst_n) begin
                m_s1[c]  = 1'b1;
                m_s2[c]  = 1'b1;
                m_deb[c] = 1'b1;
                m_tog[c] = 1'b1;
                m_run[c] = 0;
`ifdef KEY_LONG_PRESS_EN
                m_held[c] = 0;
`endif
            end else begin
                ks      = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = kif.key_n[c];
`ifdef KEY_LONG_PRESS_EN
                if (m_deb[c] == 1'b0 && m_run[c] == 0 && ks == 1'b0) begin
                    if (m_held[c] == L - 1) m_long[c] = 1'b1;
                    if (m_held[c] < L) m_held[c] = m_held[c] + 1;
                end
`endif
                if (ks != m_deb[c]) m_run[c] = m_run[c] + 1;
                else m_run[c] = 0;
                if (m_run[c] == S + 1) begin
                    m_run[c] = 0;
                    m_deb[c] = ~m_deb[c];
                    if (m_deb[c] == 1'b0) begin
                        m_press[c] = 1'b1;
                        m_tog[c]   = ~m_tog[c];
`ifdef KEY_LONG_PRESS_EN
                        m_held[c]  = 0;
`endif
                    end else begin
                        m_release[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [CH-1:0] st;
        logic [CH-1:0] tg;
        for (int c = 0; c < CH; c++) begin
            st[c] = m_deb[c];
            tg[c] = m_tog[c];
        end
`ifdef KEY_LONG_PRESS_EN
        return {st, m_press, m_release, tg, m_long};
`else
        return {st, m_press, m_release, tg};
`endif
    endfunction

    function automatic logic [VW-1:0] dut_vec();
`ifdef KEY_LONG_PRESS_EN
        return {kif.key_state, kif.key_press, kif.key_release, kif.key_toggle, kif.key_long};
`else
        return {kif.key_state, kif.key_press, kif.key_release, kif.key_toggle};
`endif
    endfunction

    // Called at a falling edge: drive, take one rising edge, return at the next falling edge.
    task automatic tick(input logic [CH-1:0] kn, input logic rn);
        kif.key_n = kn;
        rst_n     = rn;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(CH'($urandom), 1'b0);
            checks++;
            if ({kif.key_state, kif.key_press, kif.key_release, kif.key_toggle} !== {4'hf, 4'h0, 4'h0, 4'hf}) begin
                errors++;
                $display("FAIL reset_values got %h expected %h", {kif.key_state, kif.key_press, kif.key_release, kif.key_toggle}, 16'hf00f);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick('1, 1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL reset_idle edge %0d got %h expected %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        int press_edge = -1;
        int n_press    = 0;
        for (int e = 1; e <= 22; e++) begin
            tick((e <= 10) ? 4'b1110 : 4'b1111, 1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL clean_press_model edge %0d got %h expected %h", e, dut_vec(), model_vec());
            end
            if (kif.key_press[0]) begin
                n_press++;
                if (press_edge < 0) press_edge = e;
            end
            if (e == 8) begin
                checks++;
                if ({kif.key_state[0], kif.key_toggle[0]} !== 2'b00) begin
                    errors++;
                    $display("FAIL clean_press_level got state/toggle %b expected 00", {kif.key_state[0], kif.key_toggle[0]});
                end
            end
        end
        checks++;
        if (press_edge != 7 || n_press != 1) begin
            errors++;
            $display("FAIL clean_press_timing got edge %0d count %0d expected edge 7 count 1", press_edge, n_press);
        end
    endtask

    task automatic test_bounce();
        int press_edge = -1;
        int n_press    = 0;
        for (int e = 1; e <= 36; e++) begin
            tick((e <= 2 || (e >= 4 && e <= 23)) ? 4'b1101 : 4'b1111, 1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL bounce_model edge %0d got %h expected %h", e, dut_vec(), model_vec());
            end
            if (kif.key_press[1]) begin
                n_press++;
                if (press_edge < 0) press_edge = e;
            end
        end
        checks++;
        if (press_edge != 10 || n_press != 1) begin
            errors++;
            $display("FAIL bounce_single_press got edge %0d count %0d expected edge 10 count 1", press_edge, n_press);
        end
    endtask

    task automatic test_release();
        int rel_edge = -1;
        int n_rel    = 0;
        for (int e = 1; e <= 26; e++) begin
            tick((e <= 12) ? 4'b1011 : 4'b1111, 1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL release_model edge %0d got %h expected %h", e, dut_vec(), model_vec());
            end
            if (kif.key_release[2]) begin
                n_rel++;
                if (rel_edge < 0) rel_edge = e;
            end
        end
        checks++;
        if (rel_edge != 19 || n_rel != 1 || kif.key_state[2] !== 1'b1) begin
            errors++;
            $display("FAIL release_timing got edge %0d count %0d state %b expected edge 19 count 1 state 1", rel_edge, n_rel, kif.key_state[2]);
        end
    endtask

    task automatic test_simultaneous();
        int            n_cycles = 0;
        int            at_edge  = -1;
        logic [CH-1:0] seen     = '0;
        for (int e = 1; e <= 24; e++) begin
            tick((e <= 10) ? 4'b0110 : 4'b1111, 1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL simultaneous_model edge %0d got %h expected %h", e, dut_vec(), model_vec());
            end
            if (kif.key_press != '0) begin
                n_cycles++;
                at_edge = e;
                seen    = kif.key_press;
            end
        end
        checks++;
        if (n_cycles != 1 || at_edge != 7 || seen !== 4'b1001) begin
            errors++;
            $display("FAIL simultaneous_press got %b at edge %0d over %0d cycles expected 1001 at edge 7 once", seen, at_edge, n_cycles);
        end
    endtask

    task automatic test_reset_abort();
        int press_edge = -1;
        int n_press    = 0;
        for (int e = 1; e <= 32; e++) begin
            tick((e <= 20) ? 4'b1110 : 4'b1111, (e == 5) ? 1'b0 : 1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL reset_abort_model edge %0d got %h expected %h", e, dut_vec(), model_vec());
            end
            if (e == 5) begin
                checks++;
                if ({kif.key_state, kif.key_press, kif.key_release, kif.key_toggle} !== {4'hf, 4'h0, 4'h0, 4'hf}) begin
                    errors++;
                    $display("FAIL reset_abort_values got %h expected %h", {kif.key_state, kif.key_press, kif.key_release, kif.key_toggle}, 16'hf00f);
                end
            end
            if (kif.key_press[0]) begin
                n_press++;
                if (press_edge < 0) press_edge = e;
            end
        end
        checks++;
        if (press_edge != 12 || n_press != 1) begin
            errors++;
            $display("FAIL reset_abort_redetect got edge %0d count %0d expected edge 12 count 1", press_edge, n_press);
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] cur = '1;
        for (int e = 1; e <= 800; e++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
            end
            tick(cur, 1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random_model edge %0d key_n %b got %h expected %h", e, cur, dut_vec(), model_vec());
            end
        end
        for (int e = 1; e <= 12; e++) begin
            tick('1, 1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random_idle edge %0d got %h expected %h", e, dut_vec(), model_vec());
            end
        end
    endtask

`ifdef KEY_LONG_PRESS_EN
    task automatic test_long();
        int long_edge = -1;
        int n_long    = 0;
        int n_rel     = 0;
        for (int e = 1; e <= 56; e++) begin
            tick((e <= 40) ? 4'b1101 : 4'b1111, 1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL long_model edge %0d got %h expected %h", e, dut_vec(), model_vec());
            end
            if (kif.key_long[1]) begin
                n_long++;
                if (long_edge < 0) long_edge = e;
            end
            if (kif.key_release[1]) n_rel++;
        end
        checks++;
        if (long_edge != 23 || n_long != 1 || n_rel != 1) begin
            errors++;
            $display("FAIL long_press got edge %0d count %0d releases %0d expected edge 23 count 1 releases 1", long_edge, n_long, n_rel);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        kif.key_n = '1;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_abort();
`ifdef KEY_LONG_PRESS_EN
        test_long();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
